// File: rtl/cpu_divide_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cpu_divide_sequencer_pkg
// Shared definitions for the RV32M divide sequencer: operation codes, FSM
// state codes, RISC-V special-case result constants and small helpers that
// decode an operation into signedness and quotient/remainder selection.
// -----------------------------------------------------------------------------
package cpu_divide_sequencer_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'd0,
      OP_DIVU = 2'd1,
      OP_REM  = 2'd2,
      OP_REMU = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;
   localparam logic [31:0] NEG_ONE    = 32'hFFFF_FFFF;

   // DIV and REM interpret their operands as two's complement.
   function automatic logic op_is_signed(input op_e op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   // REM/REMU return the remainder, DIV/DIVU the quotient.
   function automatic logic [31:0] select_result(input op_e op,
                                                 input logic [31:0] quo,
                                                 input logic [31:0] rem);
      return ((op == OP_REM) || (op == OP_REMU)) ? rem : quo;
   endfunction

endpackage

// File: rtl/cpu_divide_special.sv
// -----------------------------------------------------------------------------
// cpu_divide_special
// Combinational detector for the two RISC-V divide cases that never go to the
// divider: division by zero and signed INT_MIN / -1 overflow.
// Ports:
//   i_signed      in   1   operation is signed (DIV/REM)
//   i_num         in   32  dividend
//   i_den         in   32  divisor
//   o_is_special  out  1   one of the special cases applies
//   o_quotient    out  32  architected quotient for the special case
//   o_remainder   out  32  architected remainder for the special case
// -----------------------------------------------------------------------------
module cpu_divide_special
   import cpu_divide_sequencer_pkg::*;
(
   input  logic        i_signed,
   input  logic [31:0] i_num,
   input  logic [31:0] i_den,
   output logic        o_is_special,
   output logic [31:0] o_quotient,
   output logic [31:0] o_remainder
);

   // Special-case classification; divide-by-zero wins over overflow.
   always_comb begin
      o_is_special = 1'b0;
      o_quotient   = 32'h0000_0000;
      o_remainder  = 32'h0000_0000;
      if (i_den == 32'h0000_0000) begin
         o_is_special = 1'b1;
         o_quotient   = DIV_ZERO_Q;
         o_remainder  = i_num;
      end else if (i_signed && (i_num == INT_MIN) && (i_den == NEG_ONE)) begin
         o_is_special = 1'b1;
         o_quotient   = INT_MIN;
         o_remainder  = 32'h0000_0000;
      end else begin
         o_is_special = 1'b0;
         o_quotient   = 32'h0000_0000;
         o_remainder  = 32'h0000_0000;
      end
   end

endmodule

// File: rtl/cpu_divide_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_divide_sequencer
// Execute-stage controller for the pipelined RV32M divider. Accepts one
// DIV/DIVU/REM/REMU request at a time, resolves special cases and cache hits
// in one cycle, otherwise drives the divider with stable operands, waits the
// divider latency and captures the selected result. A one-entry cache keeps
// the last divider quotient/remainder pair so DIV+REM on the same operands
// only uses the divider once.
// Ports:
//   i_clock, i_reset_n            clock, synchronous active-low reset
//   i_request / o_ready           request handshake
//   i_op, i_numerator, i_denominator  operation and operands
//   i_flush                       abort current operation
//   o_valid / i_accept / o_result result handshake
//   o_div_signed, o_div_numerator, o_div_denominator  divider inputs
//   i_div_result, i_div_remainder divider outputs
// -----------------------------------------------------------------------------
module cpu_divide_sequencer
   import cpu_divide_sequencer_pkg::*;
#(
   parameter int LATENCY      = 2,
   parameter bit ENABLE_CACHE = 1'b1
)(
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_request,
   output logic        o_ready,
   input  logic [1:0]  i_op,
   input  logic [31:0] i_numerator,
   input  logic [31:0] i_denominator,
   input  logic        i_flush,
   output logic        o_valid,
   input  logic        i_accept,
   output logic [31:0] o_result,
   output logic        o_div_signed,
   output logic [31:0] o_div_numerator,
   output logic [31:0] o_div_denominator,
   input  logic [31:0] i_div_result,
   input  logic [31:0] i_div_remainder
);

   state_e      state_q;
   op_e         op_q;
   logic [3:0]  cnt_q;
   logic        ready_q;
   logic        valid_q;
   logic [31:0] result_q;
   logic        div_signed_q;
   logic [31:0] div_num_q;
   logic [31:0] div_den_q;
   logic        cache_valid_q;
   logic        cache_signed_q;
   logic [31:0] cache_num_q;
   logic [31:0] cache_den_q;
   logic [31:0] cache_quo_q;
   logic [31:0] cache_rem_q;

   op_e         req_op_s;
   logic        req_signed_s;
   logic        special_s;
   logic [31:0] special_quo_s;
   logic [31:0] special_rem_s;
   logic        cache_hit_s;

   assign req_op_s     = op_e'(i_op);
   assign req_signed_s = op_is_signed(req_op_s);

   cpu_divide_special u_special (
      .i_signed     (req_signed_s),
      .i_num        (i_numerator),
      .i_den        (i_denominator),
      .o_is_special (special_s),
      .o_quotient   (special_quo_s),
      .o_remainder  (special_rem_s)
   );

   // Cache lookup against the incoming request.
   always_comb begin
      cache_hit_s = 1'b0;
      if (ENABLE_CACHE && cache_valid_q && (cache_signed_q == req_signed_s) &&
          (cache_num_q == i_numerator) && (cache_den_q == i_denominator)) begin
         cache_hit_s = 1'b1;
      end else begin
         cache_hit_s = 1'b0;
      end
   end

   // Sequencer FSM with latency counter, divider operand regs, result and cache.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         state_q        <= ST_IDLE;
         op_q           <= OP_DIV;
         cnt_q          <= 4'd0;
         ready_q        <= 1'b1;
         valid_q        <= 1'b0;
         result_q       <= 32'h0000_0000;
         div_signed_q   <= 1'b0;
         div_num_q      <= 32'h0000_0000;
         div_den_q      <= 32'h0000_0000;
         cache_valid_q  <= 1'b0;
         cache_signed_q <= 1'b0;
         cache_num_q    <= 32'h0000_0000;
         cache_den_q    <= 32'h0000_0000;
         cache_quo_q    <= 32'h0000_0000;
         cache_rem_q    <= 32'h0000_0000;
      end else if (i_flush) begin
         // Abort wherever we are; the cache keeps its previous entry.
         state_q <= ST_IDLE;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_request) begin
                  op_q    <= req_op_s;
                  ready_q <= 1'b0;
                  if (special_s) begin
                     result_q <= select_result(req_op_s, special_quo_s, special_rem_s);
                     valid_q  <= 1'b1;
                     state_q  <= ST_DONE;
                  end else if (cache_hit_s) begin
                     result_q <= select_result(req_op_s, cache_quo_q, cache_rem_q);
                     valid_q  <= 1'b1;
                     state_q  <= ST_DONE;
                  end else begin
                     div_signed_q <= req_signed_s;
                     div_num_q    <= i_numerator;
                     div_den_q    <= i_denominator;
                     cnt_q        <= 4'(LATENCY);
                     state_q      <= ST_WAIT;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               // Divider output is valid once the counter has run down.
               if (cnt_q == 4'd0) begin
                  result_q <= select_result(op_q, i_div_result, i_div_remainder);
                  valid_q  <= 1'b1;
                  state_q  <= ST_DONE;
                  if (ENABLE_CACHE) begin
                     cache_valid_q  <= 1'b1;
                     cache_signed_q <= div_signed_q;
                     cache_num_q    <= div_num_q;
                     cache_den_q    <= div_den_q;
                     cache_quo_q    <= i_div_result;
                     cache_rem_q    <= i_div_remainder;
                  end else begin
                     cache_valid_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_DONE: begin
               if (i_accept) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  state_q <= ST_DONE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_ready           = ready_q;
   assign o_valid           = valid_q;
   assign o_result          = result_q;
   assign o_div_signed      = div_signed_q;
   assign o_div_numerator   = div_num_q;
   assign o_div_denominator = div_den_q;

endmodule
